// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button mode controller.
package key_pkg;

    // Width of the debounce and hold counters.
    localparam int unsigned CNT_W = 24;

    // Default qualification times, in clock cycles.
    localparam int unsigned DEB_CYCLES_DEF  = 500;
    localparam int unsigned LONG_CYCLES_DEF = 5000;

    // Key qualification FSM states.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_FILT = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_FILT   = 2'd3
    } key_state_e;

    // Terminal count for a counter that must see n cycles.
    function automatic logic [CNT_W-1:0] cnt_last(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0.
module key_sync (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    logic stage1_q;
    logic stage2_q;

    // Shift the raw level through two flops to settle metastability.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage1_q <= 1'b0;
            stage2_q <= 1'b0;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Push-button qualifier: synchronizes and debounces an active-low key,
// produces press/release/long-press strobes and a mode bit that toggles
// on every short press.
module key_mode_ctrl
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_n,
    output logic mode,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic key_level
);

    localparam logic [CNT_W-1:0] DEB_LAST  = cnt_last(DEB_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = cnt_last(LONG_CYCLES);

    logic key_s;

    key_state_e       state_q;
    logic [CNT_W-1:0] deb_cnt_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic             long_flag_q;
    logic             mode_q;
    logic             key_level_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;

    // The key is inverted ahead of the synchronizer so that the cleared
    // flops read as "released"; the FSM sees key_s = 1 while pressed.
    key_sync u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (~key_n),
        .q_o  (key_s)
    );

    // Qualification FSM with registered strobes, level and mode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_flag_q <= 1'b0;
            mode_q      <= 1'b0;
            key_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (key_s) begin
                        state_q   <= ST_PRESS_FILT;
                        deb_cnt_q <= '0;
                    end
                end

                ST_PRESS_FILT: begin
                    if (!key_s) begin
                        // Bounce: drop back without any strobe.
                        state_q <= ST_IDLE;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q     <= ST_HELD;
                        press_q     <= 1'b1;
                        key_level_q <= 1'b1;
                        hold_cnt_q  <= '0;
                        long_flag_q <= 1'b0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end

                ST_HELD: begin
                    if (!key_s) begin
                        state_q   <= ST_REL_FILT;
                        deb_cnt_q <= '0;
                    end else begin
                        // long_flag limits the strobe to once per press,
                        // even across release bounces.
                        if ((hold_cnt_q == LONG_LAST) && !long_flag_q) begin
                            long_q      <= 1'b1;
                            long_flag_q <= 1'b1;
                        end
                        if (hold_cnt_q != LONG_LAST) begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                end

                ST_REL_FILT: begin
                    if (key_s) begin
                        // Release bounce: resume the hold where it left off.
                        state_q <= ST_HELD;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q     <= ST_IDLE;
                        release_q   <= 1'b1;
                        key_level_q <= 1'b0;
                        if (!long_flag_q) begin
                            mode_q <= ~mode_q;
                        end
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mode          = mode_q;
    assign key_level     = key_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Scoreboard bench for key_mode_ctrl with DEB_CYCLES = 4, LONG_CYCLES = 20.
module tb_key_mode_ctrl;

    localparam int K_PRESS = 0;
    localparam int K_LONG  = 1;
    localparam int K_REL   = 2;

    typedef struct {
        int   kind;
        int   edge_no;
        logic mode;
        logic level;
    } exp_t;

    logic clk;
    logic rstn;
    logic key_n;
    logic mode;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic key_level;

    int   edge_n;
    int   tests;
    int   fails;
    exp_t exp_q[$];
    logic exp_mode;
    logic prev_press;
    logic prev_rel;
    logic prev_long;

    key_mode_ctrl #(
        .DEB_CYCLES  (4),
        .LONG_CYCLES (20)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .key_n         (key_n),
        .mode          (mode),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .key_level     (key_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_n);
        end
    endtask

    task automatic push(input int kind, input int edge_no, input logic m, input logic lvl);
        exp_t e;
        e.kind    = kind;
        e.edge_no = edge_no;
        e.mode    = m;
        e.level   = lvl;
        exp_q.push_back(e);
    endtask

    // Hold key_n at v for n clocks (called and returning at a falling edge).
    task automatic drive(input logic v, input int n);
        key_n = v;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever a strobe appears.
    initial begin
        prev_press = 1'b0;
        prev_rel   = 1'b0;
        prev_long  = 1'b0;
    end

    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (press_pulse || release_pulse || long_pulse) begin
            check("pulse_exclusive", $countones({press_pulse, release_pulse, long_pulse}), 1);
            check("pulse_width", int'((press_pulse && prev_press) || (release_pulse && prev_rel) ||
                                      (long_pulse && prev_long)), 0);
            kind = press_pulse ? K_PRESS : (long_pulse ? K_LONG : K_REL);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_kind", kind, -1);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", kind, e.kind);
                check("pulse_edge", edge_n, e.edge_no);
                check("pulse_mode", int'(mode), int'(e.mode));
                check("pulse_level", int'(key_level), int'(e.level));
                $display("[TB] edge %0d kind %0d mode %0d level %0d", edge_n, kind, mode, key_level);
            end
        end
        prev_press = press_pulse;
        prev_rel   = release_pulse;
        prev_long  = long_pulse;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int r;
        tests    = 0;
        fails    = 0;
        exp_mode = 1'b0;
        rstn     = 1'b0;
        key_n    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mode", int'(mode), 0);
        check("rst_level", int'(key_level), 0);
        check("rst_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Long press: 30 clocks low.
        s = edge_n + 1;
        push(K_PRESS, s + 6,  exp_mode, 1'b1);
        push(K_LONG,  s + 26, exp_mode, 1'b1);
        push(K_REL,   s + 36, exp_mode, 1'b0);
        drive(1'b0, 30);
        drive(1'b1, 12);

        // Two short presses: mode 0 -> 1 -> 0.
        repeat (2) begin
            s = edge_n + 1;
            push(K_PRESS, s + 6, exp_mode, 1'b1);
            exp_mode = ~exp_mode;
            push(K_REL, s + 18, exp_mode, 1'b0);
            drive(1'b0, 12);
            drive(1'b1, 12);
        end

        // Glitches of 1..3 low clocks separated by one high clock.
        for (int g = 1; g <= 3; g++) begin
            drive(1'b0, g);
            drive(1'b1, 1);
            check("glitch_level", int'(key_level), 0);
        end
        drive(1'b1, 10);
        check("glitch_level_end", int'(key_level), 0);
        check("glitch_mode", int'(mode), int'(exp_mode));

        // Release bounce after the long strobe: no repeat, no release.
        s = edge_n + 1;
        push(K_PRESS, s + 6,  exp_mode, 1'b1);
        push(K_LONG,  s + 26, exp_mode, 1'b1);
        push(K_REL,   s + 48, exp_mode, 1'b0);
        drive(1'b0, 30);
        drive(1'b1, 2);
        drive(1'b0, 10);
        drive(1'b1, 12);

        // Release bounce before the long strobe: hold count is preserved.
        s = edge_n + 1;
        push(K_PRESS, s + 6,  exp_mode, 1'b1);
        push(K_LONG,  s + 29, exp_mode, 1'b1);
        push(K_REL,   s + 40, exp_mode, 1'b0);
        drive(1'b0, 12);
        drive(1'b1, 2);
        drive(1'b0, 20);
        drive(1'b1, 12);

        // Short press to leave mode at 1 before the reset case.
        s = edge_n + 1;
        push(K_PRESS, s + 6, exp_mode, 1'b1);
        exp_mode = ~exp_mode;
        push(K_REL, s + 18, exp_mode, 1'b0);
        drive(1'b0, 12);
        drive(1'b1, 12);

        // Reset 10 clocks into a held press, key stays low.
        s = edge_n + 1;
        push(K_PRESS, s + 6, exp_mode, 1'b1);
        drive(1'b0, 16);
        rstn = 1'b0;
        #1;
        check("midrst_mode", int'(mode), 0);
        check("midrst_level", int'(key_level), 0);
        check("midrst_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
        exp_mode = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        r = edge_n + 1;
        push(K_PRESS, r + 6, exp_mode, 1'b1);
        exp_mode = ~exp_mode;
        push(K_REL, r + 18, exp_mode, 1'b0);
        drive(1'b0, 12);
        drive(1'b1, 12);

        check("queue_empty", exp_q.size(), 0);
        check("final_mode", int'(mode), int'(exp_mode));
        check("final_level", int'(key_level), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
